// File: rtl/seg_scan_multiplexer.sv
// Time-multiplexed 7-segment scan driver with hex decode, dp, blank/blink,
// leading-zero suppression, frame-coherent input snapshot and frame tick.
module seg_scan_multiplexer #(
   parameter int NUM_DIGITS      = 6,
   parameter int DIGIT_CYCLES    = 50000,
   parameter int DEADTIME_CYCLES = 2,
   parameter int BLINK_FRAMES    = 64,
   parameter int SEG_ACTIVE_HIGH = 1,
   parameter int DIG_ACTIVE_LOW  = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] digits_i,
   input  logic [NUM_DIGITS-1:0]   dp_i,
   input  logic [NUM_DIGITS-1:0]   blank_i,
   input  logic [NUM_DIGITS-1:0]   blink_i,
   input  logic                    lz_en_i,
   output logic [NUM_DIGITS-1:0]   sm_bit,
   output logic [7:0]              sm_seg,
   output logic                    frame_tick
);

   localparam int SW = $clog2(DIGIT_CYCLES);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [NUM_DIGITS-1:0] BIT_OFF =
      {NUM_DIGITS{DIG_ACTIVE_LOW != 0}};
   localparam logic [7:0] SEG_OFF =
      (SEG_ACTIVE_HIGH != 0) ? 8'h00 : 8'hFF;

   logic [SW-1:0]           slot_cnt;
   logic [IW-1:0]           idx;
   logic [BW-1:0]           blink_cnt;
   logic                    blink_phase;
   logic [4*NUM_DIGITS-1:0] snap_dig;
   logic [NUM_DIGITS-1:0]   snap_dp;
   logic [NUM_DIGITS-1:0]   snap_blank;
   logic [NUM_DIGITS-1:0]   snap_blink;
   logic                    snap_lz;

   logic                    slot_last;
   logic                    idx_last;
   logic                    load;
   logic                    run;
   logic [NUM_DIGITS-1:0]   sup;
   logic [NUM_DIGITS-1:0]   dark;
   logic [3:0]              cur_nib;
   logic                    cur_dp;
   logic                    cur_dark;
   logic [NUM_DIGITS-1:0]   cur_bit;
   logic [7:0]              raw_seg;
   logic [NUM_DIGITS-1:0]   bit_nxt;
   logic [7:0]              seg_nxt;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] s;
      unique case (n)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         4'hF: s = 7'h71;
      endcase
      return s;
   endfunction

   assign slot_last = (slot_cnt == SW'(DIGIT_CYCLES - 1));
   assign idx_last  = (idx == IW'(NUM_DIGITS - 1));
   assign load      = (idx == '0) && (slot_cnt == '0);

   // A digit is suppressed while every digit from it up to the MSD is a bare 0.
   always_comb begin
      sup = '0;
      run = snap_lz;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         run    = run && (snap_dig[4*i +: 4] == 4'h0) && !snap_dp[i];
         sup[i] = run;
      end
   end

   assign dark = snap_blank | sup |
                 (snap_blink & {NUM_DIGITS{blink_phase}});

   always_comb begin
      cur_nib  = '0;
      cur_dp   = 1'b0;
      cur_dark = 1'b1;
      cur_bit  = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx == IW'(i)) begin
            cur_nib    = snap_dig[4*i +: 4];
            cur_dp     = snap_dp[i];
            cur_dark   = dark[i];
            cur_bit[i] = 1'b1;
         end
      end
      raw_seg = {cur_dp, hex7(cur_nib)};
      bit_nxt = BIT_OFF;
      seg_nxt = SEG_OFF;
      if (slot_cnt >= SW'(DEADTIME_CYCLES) && !cur_dark) begin
         bit_nxt = (DIG_ACTIVE_LOW != 0) ? ~cur_bit : cur_bit;
         seg_nxt = (SEG_ACTIVE_HIGH != 0) ? raw_seg : ~raw_seg;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_cnt    <= '0;
         idx         <= '0;
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
         snap_dig    <= '0;
         snap_dp     <= '0;
         snap_blank  <= '0;
         snap_blink  <= '0;
         snap_lz     <= 1'b0;
         frame_tick  <= 1'b0;
         sm_bit      <= BIT_OFF;
         sm_seg      <= SEG_OFF;
      end else begin
         slot_cnt <= slot_last ? '0 : slot_cnt + SW'(1);
         if (slot_last)
            idx <= idx_last ? '0 : idx + IW'(1);
         frame_tick <= load;
         if (load) begin
            snap_dig   <= digits_i;
            snap_dp    <= dp_i;
            snap_blank <= blank_i;
            snap_blink <= blink_i;
            snap_lz    <= lz_en_i;
            if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
               blink_cnt   <= '0;
               blink_phase <= ~blink_phase;
            end else begin
               blink_cnt <= blink_cnt + BW'(1);
            end
         end
         sm_bit <= bit_nxt;
         sm_seg <= seg_nxt;
      end
   end

endmodule

// File: doc/seg_scan_multiplexer.md
Name: seg_scan_multiplexer

Overview:
Parametrised time-multiplexed 7-segment scan driver for the stopwatch/clock displays; successor of the fixed 6-digit BCD scanner.
- Digit count, slot length, ghosting dead-time and segment/digit polarity are parameters.
- Adds full hex decode, per-digit decimal point, blanking and blinking, leading-zero suppression, frame-coherent input snapshot and a frame tick.
- Sits between the time-keeping counters and the board's digit-select/segment pins.

Parameters:
NUM_DIGITS, 6, number of digits scanned (1..16)
DIGIT_CYCLES, 50000, clk cycles per digit slot (>= DEADTIME_CYCLES+2)
DEADTIME_CYCLES, 2, cycles at the start of each slot with all outputs off (>= 1)
BLINK_FRAMES, 64, full scan frames per blink half-period (>= 1)
SEG_ACTIVE_HIGH, 1, 1 = segment lit by 1 (common cathode); 0 = all 8 seg bits inverted
DIG_ACTIVE_LOW, 1, 1 = digit enabled by 0; 0 = enabled by 1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
digits_i  in  4*NUM_DIGITS  hex nibbles; digit i = [4i+3:4i], digit 0 = rightmost/least significant
dp_i  in  NUM_DIGITS  decimal point request per digit
blank_i  in  NUM_DIGITS  force digit dark
blink_i  in  NUM_DIGITS  digit blinks
lz_en_i  in  1  enable leading-zero suppression
sm_bit  out  NUM_DIGITS  digit select, bit i drives digit i
sm_seg  out  8  segments {dp,g,f,e,d,c,b,a}
frame_tick  out  1  one-cycle pulse per scan frame

Behaviour:
- Reset, async while rst_n=0:
  - slot_cnt=0, idx=0, blink_cnt=0, blink_phase=0, snapshot=0, frame_tick=0.
  - sm_bit all inactive: all 1s if DIG_ACTIVE_LOW, else 0s.
  - sm_seg dark: 0x00 if SEG_ACTIVE_HIGH, else 0xFF.
- Counters:
  - slot_cnt counts 0..DIGIT_CYCLES-1.
  - On wrap, idx increments 0..NUM_DIGITS-1, then wraps to 0.
  - A frame = NUM_DIGITS slots = NUM_DIGITS*DIGIT_CYCLES cycles.
- Snapshot:
  - On every posedge where idx==0 and slot_cnt==0 (including the first cycle after reset), digits_i, dp_i, blank_i, blink_i and lz_en_i are registered into snapshot.
  - All decode uses the snapshot only. Input changes mid-frame never alter the current frame (no tearing).
- frame_tick: registered; high for exactly the one cycle following each snapshot load.
- Blink:
  - blink_cnt increments at each snapshot load.
  - At BLINK_FRAMES-1 it returns to 0 and blink_phase toggles.
  - While blink_phase=1, digits with snapshot blink bit set are dark.
- Leading-zero suppression (snapshot lz_en=1):
  - Digit i >= 1 is suppressed iff, for every j with i <= j <= NUM_DIGITS-1, nibble j == 0 and dp j == 0.
  - Digit 0 is never suppressed.
- Dark digit (blank, blink-off or suppressed): sm_bit inactive for the whole slot, sm_seg dark.
- Outputs are registered and lag the counters by exactly one cycle:
  - slot_cnt < DEADTIME_CYCLES: all digits inactive, seg dark (anti-ghosting).
  - Otherwise, if digit idx is not dark: only bit idx of sm_bit active. sm_seg = decode(nibble idx) with bit7 = dp idx, then polarity applied.
- Hex decode (active-high, bit7=0):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Reset mid-frame: outputs go dark immediately (async). After release, scanning restarts at idx 0 with a fresh snapshot.
- NUM_DIGITS=1: idx is constant 0, every slot is a frame.

Test Plan:
- Reset: rst_n=0 mid-scan (defaults) -> sm_bit=6'b111111, sm_seg=8'h00, frame_tick=0 at once. After release, first active output in slot 0 at cycle DEADTIME_CYCLES+1.
- Scan order (NUM_DIGITS=6, DIGIT_CYCLES=8, DEADTIME_CYCLES=2), digits_i=24'h123456:
  - Each slot: 2 dark cycles, then 6 cycles of (111110,7D), (111101,6D), (111011,66), (110111,4F), (101111,5B), (011111,06).
  - frame_tick every 48 cycles.
- Hex and dp: digits_i=24'hABCDEF, dp_i=6'b000100 -> seg codes 71,79,DE,39,7C,77 for digits 0..5 (digit 2 carries dp).
- Leading zeros, lz_en_i=1:
  - 24'h000042 -> digits 5..2 dark; digit 1=66, digit 0=5B.
  - 24'h000000 -> only digit 0 lit with 3F.
  - 24'h000042 with dp_i[3]=1 -> digits 5,4 dark; digit 3 lit with BF; digit 2 lit with 3F.
- Snapshot: change digits_i during slot 3 -> no output change until the frame after the next frame_tick.
- Blink/blank/polarity (BLINK_FRAMES=2, blink_i[0]=1, blank_i[5]=1, SEG_ACTIVE_HIGH=0, DIG_ACTIVE_LOW=0):
  - Digit 0 lit for 2 frames, dark for 2, repeating.
  - Digit 5 never active.
  - Lit '8' shows sm_seg=80; idle sm_bit=0.
